// File: rtl/mult_pkg.sv
// Shared definitions for the sequential fixed-point multiplier.
// Holds the FSM state encoding, default operand format and counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_FRAC  = 6;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    // Iteration counter width for a given operand width (never zero).
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: B/ACC/Q registers, adder and Q.F result extraction.
// Ports: clk, sclr, ld, shen, latch_res, a_in, b_in -> product, ovf.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             ld,
    input  logic             shen,
    input  logic             latch_res,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    // Q is loaded with the multiplicand and consumed LSB first, so it
    // doubles as the A register. After the shift the top ACC bit is always
    // zero, so only WIDTH bits of ACC are stored.
    assign addend = q_q[0] ? b_q : '0;
    assign sum    = {1'b0, acc_q} + {1'b0, addend};

    // Full product P = {acc_q, q_q}; the result window is P[W+F-1:F]
    // and everything above it is integer overflow.
    always_ff @(posedge clk) begin
        if (sclr) begin
            b_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            if (ld) begin
                b_q   <= b_in;
                acc_q <= '0;
                q_q   <= a_in;
            end else if (shen) begin
                acc_q <= sum[WIDTH:1];
                q_q   <= {sum[0], q_q[WIDTH-1:1]};
            end
            if (latch_res) begin
                product <= {acc_q[FRAC-1:0], q_q[WIDTH-1:FRAC]};
                ovf     <= |acc_q[WIDTH-1:FRAC];
            end
        end
    end

endmodule

// File: rtl/seq_fixed_multiplier.sv
// Sequential unsigned Q(W-F).F multiplier with start/done handshake.
// Ports: clk, sclr, start, a_in, b_in -> ready, done, product, ovf.
module seq_fixed_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    localparam int CW = cnt_w(WIDTH);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            ld;
    logic            shen;
    logic            latch_res;
    logic            last;

    assign last = (cnt == CW'(WIDTH - 1));

    // done is registered alongside the result latch, so it lands in the
    // first IDLE cycle; ready is held off for that cycle to keep the two
    // strobes mutually exclusive.
    assign ready = (state == IDLE) && !done;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= latch_res;
            if (ld) begin
                cnt <= '0;
            end else if (shen) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        shen      = 1'b0;
        latch_res = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ld        = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                shen = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                latch_res = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    mult_datapath #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_dp (
        .clk       (clk),
        .sclr      (sclr),
        .ld        (ld),
        .shen      (shen),
        .latch_res (latch_res),
        .a_in      (a_in),
        .b_in      (b_in),
        .product   (product),
        .ovf       (ovf)
    );

endmodule

// File: doc/seq_fixed_multiplier.md
# seq_fixed_multiplier

Sequential shift-add multiplier for unsigned Q4.6 fixed-point operands. It is the inverse-operation companion to the team's restoring divider and uses the same start/done handshake, so both units plug into the same arithmetic controller. A `start` pulse captures `a_in` and `b_in`. One partial product is accumulated per clock for WIDTH cycles. The block then presents a Q4.6 product truncated toward zero, plus an overflow flag.

## Interface
- `WIDTH`, 10: operand and result width in bits.
- `FRAC`, 6: number of fractional bits in the operands and the result.
- `clk` input 1: clock. All state changes on the rising edge.
- `sclr` input 1: reset, synchronous and active-high. It forces IDLE and clears all registers.
- `start` input 1: request a multiply. Sampled only in IDLE.
- `a_in` input WIDTH: multiplicand, Q(WIDTH-FRAC).FRAC.
- `b_in` input WIDTH: multiplier, same format.
- `ready` output 1: high in IDLE. Reset value 1.
- `done` output 1: one-cycle pulse when the result becomes valid. Reset value 0.
- `product` output WIDTH: truncated Q4.6 result. Reset value 0.
- `ovf` output 1: integer part of the result does not fit in WIDTH-FRAC bits. Reset value 0.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: if `start` is high, load A from `a_in` and B from `b_in`, clear ACC to 0, load Q from `a_in`, clear the iteration counter, and go to CALC. Otherwise stay in IDLE.
  - CALC: compute sum = ACC[WIDTH-1:0] + (Q[0] ? B : 0), which is WIDTH+1 bits. Assign {ACC, Q} <= {sum, Q} >> 1 and increment the counter. When the counter reaches WIDTH-1, go to DONE.
  - DONE: register the result, pulse `done`, and go to IDLE.
- ACC is WIDTH+1 bits so the carry out of each add is kept. The full product P = {ACC[WIDTH-1:0], Q} is 2·WIDTH bits (Q8.12 for the defaults).
- `product` = P[WIDTH+FRAC-1:FRAC]. Lower fractional bits are truncated; there is no rounding.
- `ovf` = OR of P[2·WIDTH-1:WIDTH+FRAC]. `product` still shows the truncated low bits when `ovf` = 1.
- `product` and `ovf` are updated only in the DONE state. They hold their values until the next DONE or `sclr`.
- `start` is ignored in CALC and DONE: no restart and no queuing.
- `a_in` and `b_in` are don't-care after the capture cycle.
- `sclr` asserted in any state, including mid-CALC, has these effects on the next edge:
  - state goes to IDLE and the counter to 0;
  - ACC, Q, A, B, `product` and `ovf` go to 0;
  - `done` goes to 0 and `ready` to 1.
- `sclr` takes priority over `start` in the same cycle.

## Timing
- Edge 0: `start` is sampled in IDLE and the operands are captured. `ready` falls after edge 0.
- Edges 1 through WIDTH: iterations, 10 CALC cycles for the defaults.
- Edge WIDTH+1: the DONE-state logic drives `done`=1 for exactly one cycle, and `product` and `ovf` are valid and stable.
- Edge WIDTH+2: `ready`=1 again, so the next `start` can be taken. Issue interval is WIDTH+2 cycles (12 for the defaults).
- `ready` and `done` are never high in the same cycle.
- Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Structure
- A shared package `mult_pkg` holds:
  - the state encoding typedef (IDLE, CALC, DONE);
  - default WIDTH and FRAC;
  - the counter width `$clog2(WIDTH)`.
- One sub-module, `mult_datapath`, contains the A/B/ACC/Q registers, the adder and the result extraction. It is controlled by `ld`, `shen` and `latch_res`.
- The top level contains the FSM and the iteration counter.

## Test plan
- 1.5 × 2.0: `a_in`=0x060, `b_in`=0x080. Expect `done` 11 cycles after the `start` edge, `product`=0x0C0 (3.0), `ovf`=0.
- Maximum × maximum: 0x3FF × 0x3FF. Expect P=0xFF801, `product`=0x3E0, `ovf`=1. 8.0 × 2.0 (0x200 × 0x080) gives `product`=0x000, `ovf`=1.
- Truncation and zero:
  - 0x001 × 0x001: expect `product`=0x000, `ovf`=0.
  - 0x000 × 0x3FF: expect `product`=0x000, `ovf`=0.
- Busy and hold behaviour:
  - Pulse `start` with new operands during CALC: the result is unchanged and only one `done` pulse occurs.
  - After `done`, `product` holds for 20 idle cycles.
- Reset mid-operation: assert `sclr` at CALC iteration 5. On the next edge expect `ready`=1, `done`=0, `product`=0, `ovf`=0. A following 0x040 × 0x040 gives `product`=0x040.
- Back-to-back: `start` held high continuously with new operands each IDLE cycle. Expect `done` every 12 cycles with the correct products.
